// File: rtl/core_wb_arbiter_pkg.sv
// Shared writeback types: register-file widths, the queued write request and queue depth.
package core_wb_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  reg_num_t;
  typedef logic [15:0] hword_t;

  typedef struct packed {
    reg_num_t rd;
    word_t    value;
  } wb_req_t;

  localparam int unsigned WB_QUEUE_DEPTH = 2;

  function automatic hword_t rd_onehot(reg_num_t rd);
    return hword_t'(1) << rd;
  endfunction

endpackage

// File: rtl/core_wb_arbiter_queue.sv
// Two-entry in-order queue for single-unit writebacks: push 0/1, pop 0/1/2 per cycle.
module core_wb_queue
  import core_wb_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  wb_req_t    push_req_i,
  input  logic [1:0] pop_i,
  output logic [1:0] count_o,
  output wb_req_t    head_o,
  output wb_req_t    next_o,
  output hword_t     rd_mask_o
);

  wb_req_t    ent_q [WB_QUEUE_DEPTH];
  wb_req_t    ent_d [WB_QUEUE_DEPTH];
  logic [1:0] count_q, count_d, count_mid;

  always_comb begin
    ent_d     = ent_q;
    count_mid = count_q - pop_i;
    if (pop_i == 2'd1) begin
      ent_d[0] = ent_q[1];
    end
    count_d = count_mid;
    // Push lands behind whatever survives this cycle's pops.
    if (push_i && (count_mid < 2'(WB_QUEUE_DEPTH))) begin
      ent_d[count_mid[0]] = push_req_i;
      count_d             = count_mid + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    ent_q <= ent_d;
  end

  always_comb begin
    rd_mask_o = '0;
    for (int unsigned i = 0; i < WB_QUEUE_DEPTH; i++) begin
      if (count_q > 2'(i)) begin
        rd_mask_o = rd_mask_o | rd_onehot(ent_q[i].rd);
      end
    end
  end

  assign count_o = count_q;
  assign head_o  = ent_q[0];
  assign next_o  = ent_q[1];

endmodule

// File: rtl/core_wb_arbiter.sv
// Writeback scheduler: ALU pipes own their ports; single-unit results fill idle ports in age order.
module core_wb_arbiter
  import core_wb_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_a_valid,
  input  logic [3:0]  alu_a_rd,
  input  logic [31:0] alu_a_value,
  input  logic        alu_b_valid,
  input  logic [3:0]  alu_b_rd,
  input  logic [31:0] alu_b_value,
  input  logic        single_valid,
  input  logic [3:0]  single_rd,
  input  logic [31:0] single_value,
  output logic        wb_stall_single,
  output logic        wr_a_en,
  output logic [3:0]  wr_a_r,
  output logic [31:0] wr_a_value,
  output logic        wr_b_en,
  output logic [3:0]  wr_b_r,
  output logic [31:0] wr_b_value,
  output logic [15:0] pending_mask
);

  logic [1:0] count;
  wb_req_t    q_head, q_next, in_req, c0, c1;
  hword_t     q_mask;
  logic       accept, same_rd, a_free, b_free;
  logic       c0_vld, c1_vld, c0_on_a, c0_on_b, c1_on_b;
  logic       push;
  logic [1:0] pop;

  logic     wr_a_en_q, wr_a_en_d, wr_b_en_q, wr_b_en_d;
  reg_num_t wr_a_r_q, wr_a_r_d, wr_b_r_q, wr_b_r_d;
  word_t    wr_a_value_q, wr_a_value_d, wr_b_value_q, wr_b_value_d;

  assign wb_stall_single = (count == 2'(WB_QUEUE_DEPTH));
  assign accept          = single_valid && !wb_stall_single;
  assign in_req          = '{rd: single_rd, value: single_value};

  always_comb begin
    // The incoming result only competes for a port when nothing older is queued.
    c0_vld  = (count == 2'd0) ? accept : 1'b1;
    c0      = (count == 2'd0) ? in_req : q_head;
    c1_vld  = (count == 2'd2);
    c1      = q_next;
    same_rd = alu_a_valid && alu_b_valid && (alu_a_rd == alu_b_rd);
    // A same-rd ALU pair frees port A, but not for a write to that same register.
    a_free  = !alu_a_valid || (same_rd && (c0.rd != alu_a_rd));
    b_free  = !alu_b_valid;
    c0_on_a = c0_vld && a_free;
    c0_on_b = c0_vld && !a_free && b_free;
    c1_on_b = c1_vld && c0_on_a && b_free;

    wr_a_en_d    = (alu_a_valid && !same_rd) || c0_on_a;
    wr_a_r_d     = c0_on_a ? c0.rd : alu_a_rd;
    wr_a_value_d = c0_on_a ? c0.value : alu_a_value;

    wr_b_en_d    = alu_b_valid || c0_on_b || c1_on_b;
    wr_b_r_d     = alu_b_rd;
    wr_b_value_d = alu_b_value;
    if (c0_on_b) begin
      wr_b_r_d     = c0.rd;
      wr_b_value_d = c0.value;
    end else if (c1_on_b) begin
      wr_b_r_d     = c1.rd;
      wr_b_value_d = c1.value;
    end

    pop = 2'd0;
    if (count != 2'd0) begin
      pop = {1'b0, c0_on_a | c0_on_b} + {1'b0, c1_on_b};
    end
    push = accept && !((count == 2'd0) && (c0_on_a || c0_on_b));
  end

  core_wb_queue u_queue (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .push_i     (push),
    .push_req_i (in_req),
    .pop_i      (pop),
    .count_o    (count),
    .head_o     (q_head),
    .next_o     (q_next),
    .rd_mask_o  (q_mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_a_en_q <= 1'b0;
      wr_b_en_q <= 1'b0;
    end else begin
      wr_a_en_q <= wr_a_en_d;
      wr_b_en_q <= wr_b_en_d;
    end
  end

  always_ff @(posedge clk) begin
    wr_a_r_q     <= wr_a_r_d;
    wr_a_value_q <= wr_a_value_d;
    wr_b_r_q     <= wr_b_r_d;
    wr_b_value_q <= wr_b_value_d;
  end

  assign wr_a_en    = wr_a_en_q;
  assign wr_a_r     = wr_a_r_q;
  assign wr_a_value = wr_a_value_q;
  assign wr_b_en    = wr_b_en_q;
  assign wr_b_r     = wr_b_r_q;
  assign wr_b_value = wr_b_value_q;

  assign pending_mask = q_mask
                      | (wr_a_en_q ? rd_onehot(wr_a_r_q) : hword_t'(0))
                      | (wr_b_en_q ? rd_onehot(wr_b_r_q) : hword_t'(0));

endmodule

// File: tb/tb_core_wb_arbiter.sv
// Vector table with a scoreboard queue, plus hand-written reset sequences.
module tb_core_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_a_valid, alu_b_valid, single_valid;
  logic [3:0]  alu_a_rd, alu_b_rd, single_rd;
  logic [31:0] alu_a_value, alu_b_value, single_value;
  logic        wb_stall_single, wr_a_en, wr_b_en;
  logic [3:0]  wr_a_r, wr_b_r;
  logic [31:0] wr_a_value, wr_b_value;
  logic [15:0] pending_mask;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic a_v; logic [3:0] a_rd; logic [31:0] a_val;
    logic b_v; logic [3:0] b_rd; logic [31:0] b_val;
    logic s_v; logic [3:0] s_rd; logic [31:0] s_val;
    logic ea_en; logic [3:0] ea_r; logic [31:0] ea_val;
    logic eb_en; logic [3:0] eb_r; logic [31:0] eb_val;
    logic e_stall; logic [15:0] e_mask;
  } vec_t;

  vec_t vecs [23];
  vec_t expq [$];

  always #5 clk = ~clk;

  core_wb_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alu_a_valid     (alu_a_valid),
    .alu_a_rd        (alu_a_rd),
    .alu_a_value     (alu_a_value),
    .alu_b_valid     (alu_b_valid),
    .alu_b_rd        (alu_b_rd),
    .alu_b_value     (alu_b_value),
    .single_valid    (single_valid),
    .single_rd       (single_rd),
    .single_value    (single_value),
    .wb_stall_single (wb_stall_single),
    .wr_a_en         (wr_a_en),
    .wr_a_r          (wr_a_r),
    .wr_a_value      (wr_a_value),
    .wr_b_en         (wr_b_en),
    .wr_b_r          (wr_b_r),
    .wr_b_value      (wr_b_value),
    .pending_mask    (pending_mask)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
      input logic a_v, input logic [3:0] a_rd, input logic [31:0] a_val,
      input logic b_v, input logic [3:0] b_rd, input logic [31:0] b_val,
      input logic s_v, input logic [3:0] s_rd, input logic [31:0] s_val,
      input logic ea_en, input logic [3:0] ea_r, input logic [31:0] ea_val,
      input logic eb_en, input logic [3:0] eb_r, input logic [31:0] eb_val,
      input logic e_stall, input logic [15:0] e_mask);
    vec_t v;
    v.a_v = a_v; v.a_rd = a_rd; v.a_val = a_val;
    v.b_v = b_v; v.b_rd = b_rd; v.b_val = b_val;
    v.s_v = s_v; v.s_rd = s_rd; v.s_val = s_val;
    v.ea_en = ea_en; v.ea_r = ea_r; v.ea_val = ea_val;
    v.eb_en = eb_en; v.eb_r = eb_r; v.eb_val = eb_val;
    v.e_stall = e_stall; v.e_mask = e_mask;
    return v;
  endfunction

  function automatic vec_t idle_vec();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
  endfunction

  task automatic drive(input vec_t t);
    alu_a_valid = t.a_v; alu_a_rd = t.a_rd; alu_a_value = t.a_val;
    alu_b_valid = t.b_v; alu_b_rd = t.b_rd; alu_b_value = t.b_val;
    single_valid = t.s_v; single_rd = t.s_rd; single_value = t.s_val;
  endtask

  // Drive at the falling edge, check stimulus legality, score after the next rising edge.
  task automatic step(input vec_t t, input string tag);
    vec_t        e;
    logic [15:0] queued;
    @(negedge clk);
    drive(t);
    #1;
    if (rst_n) begin
      chk({tag, ".no_push_while_stalled"}, 32'(single_valid && wb_stall_single), 32'd0);
      queued = pending_mask;
      if (wr_a_en) queued[wr_a_r] = 1'b0;
      if (wr_b_en) queued[wr_b_r] = 1'b0;
      chk({tag, ".no_waw_on_queued"},
          32'((alu_a_valid && queued[alu_a_rd]) || (alu_b_valid && queued[alu_b_rd])), 32'd0);
    end
    expq.push_back(t);
    @(posedge clk);
    #1;
    e = expq.pop_front();
    chk({tag, ".wr_a_en"}, 32'(wr_a_en), 32'(e.ea_en));
    chk({tag, ".wr_b_en"}, 32'(wr_b_en), 32'(e.eb_en));
    chk({tag, ".stall"}, 32'(wb_stall_single), 32'(e.e_stall));
    chk({tag, ".pending_mask"}, 32'(pending_mask), 32'(e.e_mask));
    if (e.ea_en) begin
      chk({tag, ".wr_a_r"}, 32'(wr_a_r), 32'(e.ea_r));
      chk({tag, ".wr_a_value"}, wr_a_value, e.ea_val);
    end
    if (e.eb_en) begin
      chk({tag, ".wr_b_r"}, 32'(wr_b_r), 32'(e.eb_r));
      chk({tag, ".wr_b_value"}, wr_b_value, e.eb_val);
    end
  endtask

  initial begin
    //            a: v rd val        b: v rd val        s: v rd val
    //            expA: en r val      expB: en r val     stall mask
    vecs[0]  = mk(1, 3, 32'h11,   0, 0, 0,          0, 0, 0,
                  1, 3, 32'h11,   0, 0, 0,          0, 16'h0008);
    vecs[1]  = idle_vec();
    vecs[2]  = mk(0, 0, 0,        0, 0, 0,          1, 5, 32'hDEAD,
                  1, 5, 32'hDEAD, 0, 0, 0,          0, 16'h0020);
    vecs[3]  = idle_vec();
    vecs[4]  = mk(1, 1, 32'h100,  1, 8, 32'h200,    1, 6, 32'h66,
                  1, 1, 32'h100,  1, 8, 32'h200,    0, 16'h0142);
    vecs[5]  = mk(1, 1, 32'h101,  1, 8, 32'h201,    1, 7, 32'h77,
                  1, 1, 32'h101,  1, 8, 32'h201,    1, 16'h01C2);
    vecs[6]  = mk(1, 1, 32'h102,  1, 8, 32'h202,    0, 0, 0,
                  1, 1, 32'h102,  1, 8, 32'h202,    1, 16'h01C2);
    vecs[7]  = mk(0, 0, 0,        0, 0, 0,          0, 0, 0,
                  1, 6, 32'h66,   1, 7, 32'h77,     0, 16'h00C0);
    vecs[8]  = idle_vec();
    vecs[9]  = mk(1, 1, 32'h103,  1, 8, 32'h203,    1, 6, 32'h66,
                  1, 1, 32'h103,  1, 8, 32'h203,    0, 16'h0142);
    vecs[10] = mk(1, 1, 32'h104,  1, 8, 32'h204,    1, 7, 32'h77,
                  1, 1, 32'h104,  1, 8, 32'h204,    1, 16'h01C2);
    vecs[11] = mk(1, 9, 32'h900,  0, 0, 0,          0, 0, 0,
                  1, 9, 32'h900,  1, 6, 32'h66,     0, 16'h02C0);
    vecs[12] = mk(1, 9, 32'h901,  0, 0, 0,          0, 0, 0,
                  1, 9, 32'h901,  1, 7, 32'h77,     0, 16'h0280);
    vecs[13] = idle_vec();
    vecs[14] = mk(1, 2, 32'hAAAA, 1, 2, 32'hBBBB,   0, 0, 0,
                  0, 0, 0,        1, 2, 32'hBBBB,   0, 16'h0004);
    vecs[15] = idle_vec();
    vecs[16] = mk(1, 1, 32'h10,   1, 8, 32'h20,     1, 4, 32'h44,
                  1, 1, 32'h10,   1, 8, 32'h20,     0, 16'h0112);
    vecs[17] = mk(1, 2, 32'h30,   1, 2, 32'h31,     0, 0, 0,
                  1, 4, 32'h44,   1, 2, 32'h31,     0, 16'h0014);
    vecs[18] = idle_vec();
    vecs[19] = mk(1, 1, 32'h105,  1, 8, 32'h205,    1, 6, 32'h66,
                  1, 1, 32'h105,  1, 8, 32'h205,    0, 16'h0142);
    vecs[20] = mk(0, 0, 0,        0, 0, 0,          1, 7, 32'h77,
                  1, 6, 32'h66,   0, 0, 0,          0, 16'h00C0);
    vecs[21] = mk(0, 0, 0,        0, 0, 0,          0, 0, 0,
                  1, 7, 32'h77,   0, 0, 0,          0, 16'h0080);
    vecs[22] = idle_vec();

    drive(idle_vec());
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    alu_a_valid = 1'b1; alu_a_rd = 4'd3; alu_a_value = 32'h11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.wr_a_en", 32'(wr_a_en), 32'd0);
    chk("reset.wr_b_en", 32'(wr_b_en), 32'd0);
    chk("reset.pending_mask", 32'(pending_mask), 32'd0);
    chk("reset.stall", 32'(wb_stall_single), 32'd0);
    drive(idle_vec());
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      step(vecs[i], $sformatf("v%0d", i));
    end

    // Fill the queue, then pull reset between edges while both ports are busy.
    step(vecs[9], "ar_fill0");
    step(vecs[10], "ar_fill1");
    #2 rst_n = 1'b0;
    drive(idle_vec());
    #1;
    chk("async_rst.wr_a_en", 32'(wr_a_en), 32'd0);
    chk("async_rst.wr_b_en", 32'(wr_b_en), 32'd0);
    chk("async_rst.stall", 32'(wb_stall_single), 32'd0);
    chk("async_rst.pending_mask", 32'(pending_mask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(idle_vec(), "ar_post0");
    step(idle_vec(), "ar_post1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_wb_arbiter.md
# core_wb_arbiter

Writeback scheduler that shares the register file's two write ports between the dual-issue ALU pipes (A, B) and the single-issue units (mul, ldst, branch). Fixed-latency ALU results always win their own port. Single-unit results go through a 2-entry queue and drain into whichever port is idle. The block drives backpressure (`wb_stall_single`) to the single units and a pending-write mask to the dispatch hazard logic.

## Interface
- No parameters. Widths come from `core/uarch.sv`: `word` = 32 bits, `reg_num` = 4 bits, `hword` = 16 bits.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset; one clock, reset is asynchronous and active-low.
- `alu_a_valid`, `alu_b_valid` in 1: ALU pipe result valid this cycle.
- `alu_a_rd`, `alu_b_rd` in `reg_num`: destination register.
- `alu_a_value`, `alu_b_value` in `word`: result.
- `single_valid` in 1: single-unit result valid. Mul, ldst and branch are pre-muxed; at most one is valid per cycle.
- `single_rd` in `reg_num`; `single_value` in `word`.
- `wb_stall_single` out 1: queue full; the single unit must hold its result.
- `wr_a_en`, `wr_b_en` out 1: register-file write enable, registered.
- `wr_a_r`, `wr_b_r` out `reg_num`; `wr_a_value`, `wr_b_value` out `word`.
- `pending_mask` out `hword`: one-hot OR of the `rd` of every queued entry and every asserted `wr_*` port.

## Operation
- Arbitration happens in cycle N. Candidates:
  - `alu_a`, `alu_b`;
  - queue head (Q0) and Q1;
  - an incoming single result, which bypasses the queue only when the queue is empty.
- Port A priority: `alu_a` > oldest single candidate.
- Port B priority: `alu_b` > next-oldest single candidate not already placed on port A.
- Up to two single-unit entries retire per cycle, and only in age order. Q1 never writes before Q0.
- Unselected single candidates stay in or enter the queue, preserving order.
- Queue count is 0..2. `wb_stall_single = (count == 2)`, combinational from registered state.
- If `single_valid` is asserted while `wb_stall_single` = 1, it is ignored. This is a protocol violation and the bench flags it.
- Precondition enforced by dispatch through `pending_mask`: no ALU result targets an `rd` that is currently queued (WAW). The bench asserts this.
- If `alu_a_rd == alu_b_rd` with both valid: only port B writes, because B is the younger instruction. `wr_a_en` = 0 that cycle. A queued single candidate may use the freed port A only if its `rd` differs.
- Flush does not affect this block. Every result it receives is architecturally committed.
- Reset values: count = 0, `wr_a_en` = `wr_b_en` = 0, `wb_stall_single` = 0, `pending_mask` = 0. `wr_*_r` and `wr_*_value` are don't-care.

## Timing
- ALU result valid in cycle N → `wr_*` asserted in cycle N+1. Fixed latency; ALUs are never stalled.
- Single result with empty queue and a free port in cycle N → written in N+1.
- Queued entry: written in cycle M+1, where M is the first cycle a port is free for it.
- Full-queue case: count = 2 and both ALUs idle in cycle N → both entries written in N+1, and `wb_stall_single` drops in N+1.
- Full-queue case: count = 2 and one port free → one entry pops; `wb_stall_single` drops in N+1 unless a new single result was also accepted that cycle (impossible, since stall was high).
- Reset mid-operation: queue contents are discarded immediately (asynchronous); write enables go low without waiting for a clock edge.

## Structure
- Shared package additions: `wb_req` struct {`rd` : `reg_num`; `value` : `word`} and `WB_QUEUE_DEPTH` = 2.
- Sub-module `core_wb_queue`: 2-entry in-order queue.
  - Push 0/1 per cycle; pop 0/1/2 per cycle.
  - Outputs `count`, head entries and a one-hot `rd` mask.
  - Asynchronous active-low reset on `count` only.
- Top level: arbitration logic, bypass and output registers. Roughly 200 RTL lines total.

## Test plan
- Reset: hold `rst_n` = 0 while `alu_a_valid` = 1 → `wr_a_en` = 0, `pending_mask` = 0, `wb_stall_single` = 0. After release, `alu_a` (`rd` = 3, value 0x11) → `wr_a_en` = 1, `wr_a_r` = 3 in the next cycle.
- Bypass: both ALUs idle, single (`rd` = 5, value 0xDEAD) → `wr_a_en` = 1, `wr_a_r` = 5, `wr_a_value` = 0xDEAD one cycle later; queue stays empty.
- Queue fill: both ALUs busy for 3 cycles while single results r6 then r7 arrive → count = 2, `wb_stall_single` = 1, `pending_mask` has bits 6 and 7 set.
  - ALUs then go idle → next cycle: port A writes r6, port B writes r7; stall = 0.
- Ordering: queue holds r6, r7; only `alu_a` is valid → port B writes r6 (not r7); r7 is written the following free cycle.
- Same `rd`: `alu_a` and `alu_b` both target r2 → only `wr_b_en` = 1, with the B value.
- Async reset mid-drain: assert `rst_n` = 0 with count = 2 → `wr_*_en` and `wb_stall_single` go low before the next edge; nothing is written after release.
